// File: rtl/rom_pkg.sv
// rtl/rom_pkg.sv - sizes, types and constant contents of the 32x4 lookup ROM
package rom_pkg;

  localparam int ROM_DEPTH  = 32;
  localparam int ROM_WIDTH  = 4;
  localparam int ROM_ADDR_W = 5;

  typedef logic [ROM_WIDTH-1:0]  rom_word_t;
  typedef logic [ROM_ADDR_W-1:0] rom_addr_t;

  // word(i) = (3*i + 5) mod 16; the pattern repeats every 16 entries
  localparam rom_word_t ROM_TABLE [ROM_DEPTH] = '{
    4'd5,  4'd8,  4'd11, 4'd14, 4'd1,  4'd4,  4'd7,  4'd10,
    4'd13, 4'd0,  4'd3,  4'd6,  4'd9,  4'd12, 4'd15, 4'd2,
    4'd5,  4'd8,  4'd11, 4'd14, 4'd1,  4'd4,  4'd7,  4'd10,
    4'd13, 4'd0,  4'd3,  4'd6,  4'd9,  4'd12, 4'd15, 4'd2
  };

endpackage

// File: rtl/rom_table.sv
// rtl/rom_table.sv - combinational address to word lookup
module rom_table
  import rom_pkg::*;
(
  input  rom_addr_t addr,
  output rom_word_t word
);

  always_comb begin
    word = ROM_TABLE[addr];
  end

endmodule

// File: rtl/rom.sv
// rtl/rom.sv - registered 32x4 constant ROM with read enable
// Optional ROM_VALID_EN adds a registered data_valid output.
module rom
  import rom_pkg::*;
(
  input  logic                  CLOCK_50,
  input  logic                  read,
  output logic [ROM_WIDTH-1:0]  data_out,
  input  logic [ROM_ADDR_W-1:0] addr,
  input  logic                  reset_n
`ifdef ROM_VALID_EN
  ,
  output logic                  data_valid
`endif
);

  rom_word_t table_word;
  rom_word_t data_out_d;
  rom_word_t data_out_q;

  rom_table u_table (
    .addr (addr),
    .word (table_word)
  );

  always_comb begin
    data_out_d = data_out_q;
    if (read) begin
      data_out_d = table_word;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

`ifdef ROM_VALID_EN
  logic data_valid_d;
  logic data_valid_q;

  always_comb begin
    data_valid_d = read;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= data_valid_d;
    end
  end

  assign data_valid = data_valid_q;
`endif

endmodule

// File: tb/tb_rom.sv
// tb/tb_rom.sv - directed scoreboard bench for rom
module tb_rom;

  logic       clk;
  logic       read_i;
  logic [3:0] data_out;
  logic [4:0] addr_i;
  logic       reset_n;
`ifdef ROM_VALID_EN
  logic       data_valid;
`endif

  int total = 0;
  int bad   = 0;
  logic [3:0] sb[$];
  logic [3:0] held;

  rom dut (
    .CLOCK_50 (clk),
    .read     (read_i),
    .data_out (data_out),
    .addr     (addr_i),
    .reset_n  (reset_n)
`ifdef ROM_VALID_EN
    ,
    .data_valid (data_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] model(input int i);
    return 4'((3 * i + 5) % 16);
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic read_cycle(input int a, input string tag);
    logic [3:0] exp;
    @(negedge clk);
    read_i = 1'b1;
    addr_i = 5'(a);
    sb.push_back(model(a));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, data_out, 4'hx);
    end else begin
      exp = sb.pop_front();
      check(tag, data_out, exp);
    end
  endtask

  initial begin
    read_i  = 1'b0;
    addr_i  = '0;
    reset_n = 1'b0;
    #1;
    check("reset_initial", data_out, 4'h0);
`ifdef ROM_VALID_EN
    check("reset_valid", {3'b0, data_valid}, 4'h0);
`endif
    @(negedge clk);
    read_i = 1'b1;
    addr_i = 5'd3;
    @(posedge clk);
    #1;
    check("reset_held_low", data_out, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;
    read_i  = 1'b0;

    for (int i = 0; i <= 12; i++) read_cycle(i, $sformatf("sweep_%0d", i));

    read_cycle(2, "hold_setup");
    held = 4'd11;
    @(negedge clk);
    read_i = 1'b0;
    addr_i = 5'd5;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_%0d", k), data_out, held);
    end

    read_cycle(31, "bound_31");
    read_cycle(0, "bound_0");
    read_cycle(16, "bound_16");

    for (int i = 0; i < 32; i++) read_cycle(i, $sformatf("full_%0d", i));

    read_cycle(9, "pre_reset");
    @(negedge clk);
    read_i = 1'b1;
    addr_i = 5'd7;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", data_out, 4'h0);
`ifdef ROM_VALID_EN
    check("async_reset_valid", {3'b0, data_valid}, 4'h0);
`endif
    @(posedge clk);
    #1;
    check("reset_edge", data_out, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;
    sb.push_back(model(7));
    @(posedge clk);
    #1;
    if (sb.size() == 0) check("after_reset_sb_empty", data_out, 4'hx);
    else check("after_reset", data_out, sb.pop_front());

`ifdef ROM_VALID_EN
    @(negedge clk);
    read_i = 1'b1;
    @(posedge clk);
    #1;
    check("valid_1a", {3'b0, data_valid}, 4'h1);
    @(negedge clk);
    read_i = 1'b0;
    @(posedge clk);
    #1;
    check("valid_0", {3'b0, data_valid}, 4'h0);
    @(negedge clk);
    read_i = 1'b1;
    @(posedge clk);
    #1;
    check("valid_1b", {3'b0, data_valid}, 4'h1);
`endif

    check("sb_drained", 4'(sb.size()), 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
